seg_display_arbiter: RTL and testbench

- Shares the 8-digit seven-segment display between three requesters: the counter path, the keyboard path and the ALU result path.
- Grants ownership round-robin, with a minimum-hold preemption rule so that no requester can monopolise the display.
- Scans the owner's 32-bit value (8 hex nibbles) across the digits using time-multiplexed, active-low digit select and segment outputs.
- Sits between the datapath producers and the board seven-segment pins.

---
 rtl/seg_display_arbiter.sv | 141 ++++++++++++++
 tb/tb_seg_display_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 8-digit seven-segment display, with a minimum-hold
// preemption rule, plus a free-running digit scanner driven from the owner's value.
module seg_display_arbiter #(
   parameter int HOLD_CYCLES = 16,
   parameter int SCAN_DIV    = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [2:0]  req,
   input  logic [95:0] req_data,
   input  logic [23:0] req_mask,
   output logic [2:0]  gnt,
   output logic        owner_valid,
   output logic [7:0]  seg_sel,
   output logic [7:0]  seg_out
);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t        state_q, state_d;
   logic [2:0]    gnt_q, gnt_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [1:0]    last_q, last_d;
   logic [DW-1:0] div_q, div_d;
   logic [2:0]    digit_q, digit_d;
   logic [7:0]    sel_q, sel_d, out_q, out_d;

   logic [1:0]    win, own;
   logic          own_req, compet;
   logic [6:0]    doff;
   logic [4:0]    moff, noff;
   logic [31:0]   own_data;
   logic [7:0]    own_mask;
   logic [3:0]    nib;

   function automatic logic [7:0] hexdec(input logic [3:0] n);
      case (n)
         4'h0: hexdec = 8'hC0;  4'h1: hexdec = 8'hF9;
         4'h2: hexdec = 8'hA4;  4'h3: hexdec = 8'hB0;
         4'h4: hexdec = 8'h99;  4'h5: hexdec = 8'h92;
         4'h6: hexdec = 8'h82;  4'h7: hexdec = 8'hF8;
         4'h8: hexdec = 8'h80;  4'h9: hexdec = 8'h90;
         4'hA: hexdec = 8'h88;  4'hB: hexdec = 8'h83;
         4'hC: hexdec = 8'hC6;  4'hD: hexdec = 8'hA1;
         4'hE: hexdec = 8'h86;  default: hexdec = 8'h8E;
      endcase
   endfunction

   // Scan starts just after the last winner, so the last winner comes last.
   always_comb begin
      case (last_q)
         2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
         2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
         default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
   end

   assign own     = gnt_q[1] ? 2'd1 : (gnt_q[2] ? 2'd2 : 2'd0);
   assign own_req = |(req & gnt_q);
   assign compet  = |(req & ~gnt_q);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      hold_d  = hold_q;
      last_d  = last_q;
      case (state_q)
         IDLE, GAP: begin
            if (|req) begin
               gnt_d   = 3'b001 << win;
               hold_d  = '0;
               last_d  = win;
               state_d = GRANT;
            end else begin
               gnt_d   = '0;
               state_d = IDLE;
            end
         end
         GRANT: begin
            if (!own_req || (hold_q == HW'(HOLD_CYCLES) && compet)) begin
               gnt_d   = '0;
               state_d = GAP;
            end else if (hold_q != HW'(HOLD_CYCLES)) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Owner data and mask are taken live every cycle, not latched at grant.
   assign doff     = {own, 5'd0};
   assign moff     = {own, 3'd0};
   assign noff     = {digit_q, 2'b00};
   assign own_data = req_data[doff +: 32];
   assign own_mask = req_mask[moff +: 8];
   assign nib      = own_data[noff +: 4];

   always_comb begin
      div_d   = (div_q == DW'(SCAN_DIV - 1)) ? '0 : div_q + 1'b1;
      digit_d = (div_q == DW'(SCAN_DIV - 1)) ? digit_q + 3'd1 : digit_q;
      sel_d   = 8'hFF;
      out_d   = 8'hFF;
      if ((|gnt_q) && own_mask[digit_q]) begin
         sel_d = ~(8'b1 << digit_q);
         out_d = hexdec(nib);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         hold_q  <= '0;
         last_q  <= 2'd2;
         div_q   <= '0;
         digit_q <= '0;
         sel_q   <= 8'hFF;
         out_q   <= 8'hFF;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         hold_q  <= hold_d;
         last_q  <= last_d;
         div_q   <= div_d;
         digit_q <= digit_d;
         sel_q   <= sel_d;
         out_q   <= out_d;
      end
   end

   assign gnt         = gnt_q;
   assign owner_valid = |gnt_q;
   assign seg_sel     = sel_q;
   assign seg_out     = out_q;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed + randomized bench for seg_display_arbiter against a cycle-level
// reference model built from owner index, hold count and elapsed-cycle arithmetic.
module tb_seg_display_arbiter;
   localparam int HOLD = 16;
   localparam int SDIV = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic [2:0]  req;
   logic [95:0] req_data;
   logic [23:0] req_mask;
   logic [2:0]  gnt;
   logic        owner_valid;
   logic [7:0]  seg_sel, seg_out;

   seg_display_arbiter #(.HOLD_CYCLES(HOLD), .SCAN_DIV(SDIV)) dut (
      .clk(clk), .resetn(resetn), .req(req), .req_data(req_data), .req_mask(req_mask),
      .gnt(gnt), .owner_valid(owner_valid), .seg_sel(seg_sel), .seg_out(seg_out)
   );

   always #5 clk = ~clk;

   logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   int vec = 0, miss = 0;
   int m_owner, m_hold, m_last, m_tick;
   logic [7:0] e_sel, e_out;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_hold = 0; m_last = 2; m_tick = 0;
      e_sel = 8'hFF; e_out = 8'hFF;
   endtask

   function automatic logic [2:0] exp_gnt();
      return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt()));
      chk({tag, ".ov"}, 32'(owner_valid), 32'(m_owner >= 0));
      chk({tag, ".sel"}, 32'(seg_sel), 32'(e_sel));
      chk({tag, ".seg"}, 32'(seg_out), 32'(e_out));
   endtask

   // One clock: advance the model with the inputs seen at this edge, then compare.
   task automatic step(input string tag);
      int dig, idx;
      bit others;
      @(posedge clk);
      dig = (m_tick / SDIV) % 8;
      e_sel = 8'hFF; e_out = 8'hFF;
      if (m_owner >= 0 && req_mask[m_owner*8 + dig]) begin
         e_sel = ~(8'h01 << dig);
         e_out = HEX[req_data[m_owner*32 + dig*4 +: 4]];
      end
      m_tick++;
      if (m_owner >= 0) begin
         others = 0;
         for (int j = 0; j < 3; j++) if (j != m_owner && req[j]) others = 1;
         if (!req[m_owner] || (m_hold == HOLD && others)) m_owner = -1;
         else if (m_hold < HOLD) m_hold++;
      end else if (req != 0) begin
         for (int k = 1; k <= 3; k++) begin
            idx = (m_last + k) % 3;
            if (m_owner < 0 && req[idx]) m_owner = idx;
         end
         m_hold = 0;
         m_last = m_owner;
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      int cnt;
      resetn = 1'b0; req = '0; req_data = '0; req_mask = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      resetn = 1'b1;

      // All three request: requester 0 first, held for HOLD+1 cycles, then gap, then 1.
      req = 3'b111; req_mask = 24'hFFFFFF;
      req_data = {32'h89AB_CDEF, 32'h7654_3210, 32'h0123_89AF};
      step("first");
      chk("first_gnt", 32'(gnt), 32'h1);
      cnt = 0;
      while (gnt == 3'b001 && cnt < 40) begin cnt++; step("hold111"); end
      chk("hold_len", cnt, HOLD + 1);
      chk("gap_gnt", 32'(gnt), 32'h0);
      step("after_gap");
      chk("second_owner", 32'(gnt), 32'h2);

      // Two requesters alternate with preemption.
      req = 3'b011;
      repeat (80) step("alt011");

      // Requester 0 alone shows its value on every digit.
      req = 3'b001;
      repeat (48) step("solo0");

      // Requester 1 owns, then releases with nobody else asking.
      req = 3'b010;
      repeat (6) step("own1");
      req = 3'b000;
      step("release");
      chk("release_gnt", 32'(gnt), 32'h0);
      step("release_disp");
      chk("release_sel", 32'(seg_sel), 32'hFF);
      chk("release_seg", 32'(seg_out), 32'hFF);

      // Partial mask across a full scan, including the 7->0 wrap.
      req = 3'b001; req_mask = {8'hFF, 8'hFF, 8'h0F};
      repeat (72) step("mask0F");

      // Randomized: sticky requests, changing data and masks.
      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(0, 9) == 0) req = 3'($urandom);
         if ($urandom_range(0, 3) == 0) req_data = {$urandom, $urandom, $urandom};
         if ($urandom_range(0, 15) == 0) req_mask = 24'($urandom);
         step("rand");
      end

      // Asynchronous reset in the middle of a grant.
      req = 3'b001; req_mask = 24'hFFFFFF;
      repeat (10) step("pre_rst");
      #1 resetn = 1'b0;
      #1;
      model_reset();
      chk("arst_gnt", 32'(gnt), 32'h0);
      chk("arst_ov", 32'(owner_valid), 32'h0);
      chk("arst_sel", 32'(seg_sel), 32'hFF);
      chk("arst_seg", 32'(seg_out), 32'hFF);
      #1 resetn = 1'b1;
      req = 3'b100;
      step("post_rst");
      chk("post_rst_gnt", 32'(gnt), 32'h4);
      repeat (40) step("post_rst_run");

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
